// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// The CKSUM state exists only when PROG_LOADER_CKSUM_EN is defined.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_ADDR,
        HDR_CNT,
        DATA,
        WRITE,
`ifdef PROG_LOADER_CKSUM_EN
        CKSUM,
`endif
        FINISH
    } loader_state_e;

    localparam logic [7:0]  LOADER_MAGIC   = 8'hA5;
    localparam int unsigned HDR_ADDR_BYTES = 3;
    localparam int unsigned HDR_CNT_BYTES  = 3;
    localparam int unsigned WORD_BYTES     = 4;

    // Index of the final byte of a little-endian field of nbytes bytes.
    function automatic logic [1:0] last_index(input int unsigned nbytes);
        return 2'(nbytes - 1);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer; handles 3-byte header fields and 4-byte data words.
module word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [1:0]  last,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [31:0] shreg;
    logic [31:0] shifted;
    logic [1:0]  pad;

    // Bytes enter at the top; short fields are right-aligned on completion.
    always_comb begin
        shifted    = {data, shreg[31:8]};
        pad        = 2'd3 - last;
        word       = shifted >> {pad, 3'b000};
        word_valid = en && (idx == last);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx   <= '0;
            shreg <= '0;
        end else if (en) begin
            if (word_valid) begin
                idx   <= '0;
                shreg <= '0;
            end else begin
                idx   <= idx + 2'd1;
                shreg <= shifted;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Parses a magic/address/count/data byte frame and writes packed words to instruction RAM.
// Optional trailing checksum byte enabled by PROG_LOADER_CKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_STEP = 1,
    parameter int unsigned MAX_WORDS = 65536
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [7:0]        IN_DATA,
    output logic              IN_READY,
    output logic              LOAD_CTRL,
    output logic [DATA_W-1:0] LOAD_DATA,
    output logic [ADDR_W-1:0] LOAD_ADDR,
    output logic              CORE_HOLD,
    output logic              DONE,
    output logic              ERROR
);

`ifdef PROG_LOADER_CKSUM_EN
    localparam loader_state_e AFTER_DATA = CKSUM;
`else
    localparam loader_state_e AFTER_DATA = FINISH;
`endif

    loader_state_e     state, next_state;
    logic              accept;
    logic              is_magic;
    logic              pk_en;
    logic              pk_clear;
    logic [1:0]        pk_last;
    logic [31:0]       pk_word;
    logic              pk_valid;
    logic [23:0]       cnt_field;
    logic              cnt_over;
    logic [23:0]       remain;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              error_q;
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0]        cksum;
`endif

    assign accept    = IN_VALID && IN_READY;
    assign is_magic  = (IN_DATA == LOADER_MAGIC);
    assign pk_clear  = (state == IDLE);
    assign pk_en     = accept && (state inside {HDR_ADDR, HDR_CNT, DATA});
    assign pk_last   = (state == DATA)     ? last_index(WORD_BYTES) :
                       (state == HDR_CNT)  ? last_index(HDR_CNT_BYTES) :
                                             last_index(HDR_ADDR_BYTES);
    assign cnt_field = pk_word[23:0];
    assign cnt_over  = 32'(cnt_field) > 32'(MAX_WORDS);

    word_packer u_packer (
        .clk        (CLK),
        .rst        (RST),
        .clear      (pk_clear),
        .en         (pk_en),
        .last       (pk_last),
        .data       (IN_DATA),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:     if (accept && is_magic) next_state = HDR_ADDR;
            HDR_ADDR: if (pk_valid) next_state = HDR_CNT;
            HDR_CNT: begin
                if (pk_valid) begin
                    if (cnt_field == '0) next_state = AFTER_DATA;
                    else if (cnt_over)   next_state = IDLE;
                    else                 next_state = DATA;
                end
            end
            DATA:     if (pk_valid) next_state = WRITE;
            WRITE:    next_state = (remain == 24'd1) ? AFTER_DATA : DATA;
`ifdef PROG_LOADER_CKSUM_EN
            CKSUM:    if (accept) next_state = (IN_DATA == cksum) ? FINISH : IDLE;
`endif
            FINISH:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = 1'b1;
        LOAD_CTRL = 1'b0;
        CORE_HOLD = 1'b1;
        DONE      = 1'b0;
        unique case (state)
            IDLE:   CORE_HOLD = 1'b0;
            WRITE: begin
                IN_READY  = 1'b0;
                LOAD_CTRL = 1'b1;
            end
            FINISH: begin
                IN_READY  = 1'b0;
                CORE_HOLD = 1'b0;
                DONE      = 1'b1;
            end
            default: ;
        endcase
    end

    // Write word/address are captured on the 4th data byte so they are stable during WRITE and held after.
    always_ff @(posedge CLK) begin
        if (RST) begin
            remain   <= '0;
            cur_addr <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            error_q  <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
            cksum    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && is_magic) begin
                        error_q <= 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
                        cksum   <= '0;
`endif
                    end
                end
                HDR_ADDR: if (pk_valid) cur_addr <= pk_word[ADDR_W-1:0];
                HDR_CNT: begin
                    if (pk_valid) begin
                        remain <= cnt_field;
                        if (cnt_over) error_q <= 1'b1;
                    end
                end
                DATA: begin
`ifdef PROG_LOADER_CKSUM_EN
                    if (pk_en) cksum <= cksum + IN_DATA;
`endif
                    if (pk_valid) begin
                        data_q <= DATA_W'(pk_word);
                        addr_q <= cur_addr;
                    end
                end
                WRITE: begin
                    cur_addr <= cur_addr + ADDR_W'(ADDR_STEP);
                    remain   <= remain - 24'd1;
                end
`ifdef PROG_LOADER_CKSUM_EN
                CKSUM: if (accept && (IN_DATA != cksum)) error_q <= 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign LOAD_DATA = data_q;
    assign LOAD_ADDR = addr_q;
    assign ERROR     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame table, reset-mid-frame sequence and random frames vs a frame-level model.
module tb_prog_loader;
    import prog_loader_pkg::*;

`ifdef PROG_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_READY, LOAD_CTRL, CORE_HOLD, DONE, ERROR;
    logic [31:0] LOAD_DATA;
    logic [19:0] LOAD_ADDR;

    always #5 CLK = ~CLK;

    prog_loader #(.ADDR_W(20), .DATA_W(32), .ADDR_STEP(1), .MAX_WORDS(65536)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .LOAD_CTRL(LOAD_CTRL), .LOAD_DATA(LOAD_DATA), .LOAD_ADDR(LOAD_ADDR),
        .CORE_HOLD(CORE_HOLD), .DONE(DONE), .ERROR(ERROR)
    );

    typedef struct { logic [19:0] addr; logic [31:0] data; logic hold; } wr_t;

    typedef struct {
        logic [23:0] addr; logic [23:0] cnt; int unsigned nw; logic [31:0] w0; logic [31:0] w1;
        int unsigned garbage; logic [7:0] ck_delta;
        int unsigned exp_nwr; logic [19:0] ea0; logic [19:0] ea1; logic [31:0] ed0; logic [31:0] ed1;
        int unsigned exp_done; logic exp_err;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cycle    = 0;
    int unsigned last_wr_cycle = 0;
    int unsigned done_cycle = 0;
    int unsigned done_cnt = 0;
    logic        done_hold = 1'b0;
    wr_t         wr_q[$];
    wr_t         exp_q[$];
    logic [7:0]  frame[$];
    logic [31:0] words[$];
    vec_t        vecs[7];

    always @(posedge CLK) cycle <= cycle + 1;

    always @(negedge CLK) begin
        if (!RST) begin
            if (LOAD_CTRL) begin
                wr_q.push_back('{LOAD_ADDR, LOAD_DATA, CORE_HOLD});
                last_wr_cycle = cycle;
            end
            if (DONE) begin
                done_cnt++;
                done_cycle = cycle;
                done_hold  = CORE_HOLD;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [23:0] addr, input logic [23:0] cnt,
                         input int unsigned garbage, input logic [7:0] ck_delta);
        logic [7:0] g;
        logic [7:0] sum;
        sum = 8'h00;
        frame.delete();
        for (int unsigned i = 0; i < garbage; i++) begin
            g = 8'($urandom);
            if (g == LOADER_MAGIC) g = 8'h00;
            frame.push_back(g);
        end
        frame.push_back(LOADER_MAGIC);
        for (int unsigned i = 0; i < 3; i++) frame.push_back(addr[8*i +: 8]);
        for (int unsigned i = 0; i < 3; i++) frame.push_back(cnt[8*i +: 8]);
        foreach (words[k]) begin
            for (int unsigned b = 0; b < 4; b++) begin
                frame.push_back(words[k][8*b +: 8]);
                sum = sum + words[k][8*b +: 8];
            end
        end
        if (CK_EN) frame.push_back(sum + ck_delta);
    endtask

    task automatic send_frame(input int unsigned gap_max, input int unsigned nbytes);
        int unsigned n;
        for (int unsigned k = 0; k < nbytes && k < frame.size(); k++) begin
            IN_VALID = 1'b1;
            IN_DATA  = frame[k];
            n = 0;
            while (!IN_READY && n < 50) begin
                @(negedge CLK);
                n++;
            end
            if (!IN_READY) begin
                n_checks++;
                n_fail++;
                $display("FAIL handshake: IN_READY stuck at 0 for %0d cycles, required 1", n);
            end
            @(negedge CLK);
            if (gap_max > 0) begin
                IN_VALID = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(negedge CLK);
            end
        end
        IN_VALID = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic compare(input string tag, input int unsigned exp_done, input logic exp_err);
        check({tag, ".nwrites"}, wr_q.size(), exp_q.size());
        for (int unsigned i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), 32'(wr_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s.data%0d", tag, i), wr_q[i].data, exp_q[i].data);
            check($sformatf("%s.hold%0d", tag, i), 32'(wr_q[i].hold), 32'd1);
        end
        check({tag, ".done"}, done_cnt, exp_done);
        check({tag, ".error"}, 32'(ERROR), 32'(exp_err));
        check({tag, ".hold_idle"}, 32'(CORE_HOLD), 32'd0);
        if (done_cnt == 1) begin
            check({tag, ".done_hold"}, 32'(done_hold), 32'd0);
            if (!CK_EN && exp_q.size() > 0)
                check({tag, ".done_lat"}, done_cycle - last_wr_cycle, 32'd1);
        end
        wr_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"},  32'(IN_READY),  32'd1);
        check({tag, ".load_ctrl"}, 32'(LOAD_CTRL), 32'd0);
        check({tag, ".load_data"}, LOAD_DATA,      32'd0);
        check({tag, ".load_addr"}, 32'(LOAD_ADDR), 32'd0);
        check({tag, ".core_hold"}, 32'(CORE_HOLD), 32'd0);
        check({tag, ".done"},      32'(DONE),      32'd0);
        check({tag, ".error"},     32'(ERROR),     32'd0);
    endtask

    initial begin
        logic [23:0] r_addr, r_cnt;
        logic        r_over;

        vecs[0] = '{24'h000000, 24'h000000, 0, 32'h0, 32'h0, 3, 8'h00,
                    0, 20'h0, 20'h0, 32'h0, 32'h0, 1, 1'b0};
        vecs[1] = '{24'h001000, 24'h000002, 2, 32'h00000013, 32'h0000006F, 0, 8'h00,
                    2, 20'h01000, 20'h01001, 32'h00000013, 32'h0000006F, 1, 1'b0};
        vecs[2] = '{24'h000300, 24'h010001, 0, 32'h0, 32'h0, 0, 8'h00,
                    0, 20'h0, 20'h0, 32'h0, 32'h0, 0, 1'b1};
        vecs[3] = '{24'h0FFFFF, 24'h000002, 2, 32'hDEADBEEF, 32'h12345678, 0, 8'h00,
                    2, 20'hFFFFF, 20'h00000, 32'hDEADBEEF, 32'h12345678, 1, 1'b0};
        vecs[4] = '{24'hABCDEF, 24'h000001, 1, 32'hA5A5A5A5, 32'h0, 2, 8'h00,
                    1, 20'hBCDEF, 20'h0, 32'hA5A5A5A5, 32'h0, 1, 1'b0};
        vecs[5] = '{24'h000040, 24'h000001, 1, 32'h04030201, 32'h0, 0, 8'h01,
                    1, 20'h00040, 20'h0, 32'h04030201, 32'h0, CK_EN ? 0 : 1, CK_EN};
        vecs[6] = '{24'h000040, 24'h000001, 1, 32'h04030201, 32'h0, 0, 8'h00,
                    1, 20'h00040, 20'h0, 32'h04030201, 32'h0, 1, 1'b0};

        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        foreach (vecs[v]) begin
            words.delete();
            if (vecs[v].nw > 0) words.push_back(vecs[v].w0);
            if (vecs[v].nw > 1) words.push_back(vecs[v].w1);
            if (vecs[v].exp_nwr > 0) exp_q.push_back('{vecs[v].ea0, vecs[v].ed0, 1'b1});
            if (vecs[v].exp_nwr > 1) exp_q.push_back('{vecs[v].ea1, vecs[v].ed1, 1'b1});
            build(vecs[v].addr, vecs[v].cnt, vecs[v].garbage, vecs[v].ck_delta);
            send_frame(0, frame.size());
            compare($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
        end

        // Reset after two data bytes of the first word, then a full frame.
        words.delete();
        words.push_back(32'h11223344);
        build(24'h000200, 24'h000001, 0, 8'h00);
        send_frame(0, 9);
        check("rst_mid.hold_before", 32'(CORE_HOLD), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("rst_mid");
        check("rst_mid.nwrites", wr_q.size(), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        exp_q.push_back('{20'h00200, 32'h11223344, 1'b1});
        send_frame(0, frame.size());
        compare("after_rst", 1, 1'b0);

        // Random frames against a frame-level model.
        for (int unsigned f = 0; f < 20; f++) begin
            r_addr = 24'($urandom);
            r_over = ($urandom_range(0, 5) == 0);
            r_cnt  = r_over ? 24'($urandom_range(65537, 24'hFFFFFF)) : 24'($urandom_range(0, 5));
            words.delete();
            if (!r_over) begin
                for (int unsigned i = 0; i < r_cnt; i++) begin
                    words.push_back($urandom);
                    exp_q.push_back('{20'((r_addr % (1 << 20) + i) % (1 << 20)), words[i], 1'b1});
                end
            end
            build(r_addr, r_cnt, $urandom_range(0, 3), 8'h00);
            send_frame(2, frame.size());
            compare($sformatf("rand%0d", f), r_over ? 0 : 1, r_over);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
